// File: rtl/oai31_seq_pkg.sv
// Shared types, sweep constants and stimulus/expectation helpers for the oai31 arc sequencer.
// The sweep is 16 static vectors followed by 7 B-arc triplets.
package oai31_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STATIC,
    ARC,
    FIN
  } state_t;

  localparam int         N_STATIC  = 16;
  localparam int         N_ARC     = 21;
  localparam int         N_SAMPLES = N_STATIC + N_ARC;
  localparam logic [5:0] NO_FAIL   = 6'd63;
  localparam logic [5:0] LAST_IDX  = 6'(N_SAMPLES - 1);

  function automatic logic oai31_exp(input logic a1, input logic a2, input logic a3, input logic b);
    return ~((a1 | a2 | a3) & b);
  endfunction

  // Stimulus {a1,a2,a3,b} for sample s. Arc samples hold A=c and toggle B as 0,1,0.
  function automatic logic [3:0] arc_vec(input logic [5:0] s);
    logic [5:0] rel;
    logic [2:0] c;
    logic [1:0] pos;
    rel = s - 6'(N_STATIC);
    c   = 3'(rel / 6'd3) + 3'd1;
    pos = 2'(rel % 6'd3);
    if (s < 6'(N_STATIC)) begin
      return s[3:0];
    end
    return {c, (pos == 2'd1)};
  endfunction

endpackage

// File: rtl/oai31_settle_timer.sv
// Settle timer: loads SETTLE-1, counts down, and flags the last cycle of a sample window.
// SETTLE below 1 behaves as 1.
module oai31_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last
);

  localparam int            SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int            CW         = $clog2(SETTLE_EFF + 1);
  localparam logic [CW-1:0] RELOAD     = CW'(SETTLE_EFF - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/oai31_arc_sequencer.sv
// Stimulus/capture sequencer around one oai31 cell: sweeps static vectors then B arcs,
// scoring every sample of ZN against the ideal function.
module oai31_arc_sequencer
  import oai31_seq_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       ZN,
  output logic       A1,
  output logic       A2,
  output logic       A3,
  output logic       B,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [5:0] ERR_CNT,
  output logic [5:0] FAIL_IDX
);

  state_t     state, state_next;
  logic [5:0] idx, idx_next;
  logic [3:0] stim, stim_next;
  logic       busy, busy_next;
  logic       done, done_next;
  logic       pass, pass_next;
  logic [5:0] err_cnt, err_next;
  logic [5:0] fail_idx, fail_next;
  logic       load;
  logic       last;
  logic       expect_zn;
  logic       miss;

  oai31_settle_timer #(
    .SETTLE(SETTLE)
  ) u_timer (
    .clk (CLK),
    .rst (RST),
    .load(load),
    .last(last)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      idx      <= '0;
      stim     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      fail_idx <= NO_FAIL;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      stim     <= stim_next;
      busy     <= busy_next;
      done     <= done_next;
      pass     <= pass_next;
      err_cnt  <= err_next;
      fail_idx <= fail_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    stim_next  = stim;
    busy_next  = busy;
    done_next  = 1'b0;
    pass_next  = pass;
    err_next   = err_cnt;
    fail_next  = fail_idx;
    load       = 1'b0;
    expect_zn  = oai31_exp(stim[3], stim[2], stim[1], stim[0]);
    // X/Z on the cell output must score as a failure, hence case inequality.
    miss       = (ZN !== expect_zn);

    case (state)
      IDLE: begin
        if (START) begin
          state_next = STATIC;
          idx_next   = '0;
          stim_next  = arc_vec(6'd0);
          busy_next  = 1'b1;
          pass_next  = 1'b0;
          err_next   = '0;
          fail_next  = NO_FAIL;
          load       = 1'b1;
        end
      end
      STATIC, ARC: begin
        if (last) begin
          if (miss) begin
            err_next = err_cnt + 6'd1;
            if (fail_idx == NO_FAIL) begin
              fail_next = idx;
            end
          end
          if (idx == LAST_IDX) begin
            state_next = FIN;
            stim_next  = '0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            pass_next  = (err_next == 6'd0);
          end else begin
            idx_next   = idx + 6'd1;
            stim_next  = arc_vec(idx_next);
            load       = 1'b1;
            state_next = (idx_next >= 6'(N_STATIC)) ? ARC : STATIC;
          end
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign A1       = stim[3];
  assign A2       = stim[2];
  assign A3       = stim[1];
  assign B        = stim[0];
  assign BUSY     = busy;
  assign DONE     = done;
  assign PASS     = pass;
  assign ERR_CNT  = err_cnt;
  assign FAIL_IDX = fail_idx;

endmodule
